// File: rtl/bls_pkg.sv
// Shared constants for the iterative add/subtract unit: operation codes,
// FSM state encoding and the default lookahead group size.
package bls_pkg;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DEFAULT_GROUP = 4;

   // Digit counter width; a single-digit operand still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bls_group_slice.sv
// GROUP-bit combinational add/subtract slice with a fully expanded
// generate/propagate lookahead; the chain bit is carry (add) or borrow (sub).
module bls_group_slice
   import bls_pkg::*;
#(
   parameter int GROUP = DEFAULT_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             mode,
   input  logic             chain_in,
   output logic [GROUP-1:0] res,
   output logic             chain_out
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   ch;

   // Borrow generates when a=0,b=1 and propagates when the bits are equal.
   always_comb begin
      if (mode == MODE_ADD) begin
         g = a & b;
         p = a ^ b;
      end else begin
         g = ~a & b;
         p = ~(a ^ b);
      end
   end

   // Sum-of-products for chain bit i+1, each term built directly from c0.
   function automatic logic lookahead(input int i,
                                      input logic [GROUP-1:0] gg,
                                      input logic [GROUP-1:0] pp,
                                      input logic c0);
      logic acc;
      logic term;
      acc = c0;
      for (int k = 0; k <= i; k++) acc = acc & pp[k];
      for (int j = 0; j <= i; j++) begin
         term = gg[j];
         for (int k = j + 1; k <= i; k++) term = term & pp[k];
         acc = acc | term;
      end
      return acc;
   endfunction

   always_comb begin
      ch[0] = chain_in;
      for (int i = 0; i < GROUP; i++) begin
         ch[i+1] = lookahead(i, g, p, chain_in);
      end
   end

   assign res       = (mode == MODE_ADD) ? (p ^ ch[GROUP-1:0]) : ~(p ^ ch[GROUP-1:0]);
   assign chain_out = ch[GROUP];

endmodule

// File: rtl/bls_iter_addsub.sv
// Multi-cycle add/subtract: one GROUP-bit digit per clock, LSB digit first,
// with the carry/borrow chained between digits through a register.
module bls_iter_addsub
   import bls_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = DEFAULT_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int N     = WIDTH / GROUP;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] x_sh;
   logic [WIDTH-1:0] y_sh;
   logic             mode_q;
   logic             chain;
   logic             accept;
   logic [GROUP-1:0] digit_res;
   logic             digit_chain;
   logic [WIDTH-1:0] result_next;
   logic             ovf_next;

   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_DONE);
   assign accept = start && (state != ST_RUN);

   bls_group_slice #(.GROUP(GROUP)) u_slice (
      .a         (x_sh[GROUP-1:0]),
      .b         (y_sh[GROUP-1:0]),
      .mode      (mode_q),
      .chain_in  (chain),
      .res       (digit_res),
      .chain_out (digit_chain)
   );

   always_comb begin
      result_next = result;
      for (int d = 0; d < N; d++) begin
         if (cnt == CNT_W'(d)) result_next[d*GROUP +: GROUP] = digit_res;
      end
   end

   // On the last digit the slice inputs hold the operand MSBs.
   always_comb begin
      if (mode_q == MODE_ADD) begin
         ovf_next = (x_sh[GROUP-1] == y_sh[GROUP-1]) && (digit_res[GROUP-1] != x_sh[GROUP-1]);
      end else begin
         ovf_next = (x_sh[GROUP-1] != y_sh[GROUP-1]) && (digit_res[GROUP-1] != x_sh[GROUP-1]);
      end
   end

   // Operand shift registers carry no reset; they are only read during RUN.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_sh   <= x;
         y_sh   <= y;
         mode_q <= mode;
      end else if (state == ST_RUN) begin
         x_sh <= x_sh >> GROUP;
         y_sh <= y_sh >> GROUP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         chain  <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               result <= result_next;
               chain  <= digit_chain;
               if (cnt == LAST) begin
                  state <= ST_DONE;
                  cout  <= digit_chain;
                  zero  <= (result_next == '0);
                  ovf   <= ovf_next;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (start) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  chain <= cin;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
